// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, power modes and FSM encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    localparam logic [1:0] PM_DIV1 = 2'b00;
    localparam logic [1:0] PM_DIV2 = 2'b01;
    localparam logic [1:0] PM_DIV4 = 2'b10;
    localparam logic [1:0] PM_DIV8 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Opcodes 110 and 111 have no ALU operation behind them.
    function automatic logic op_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer with registered full/empty flags.
module alu_cmd_fifo #(
    parameter int W     = 67,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_r;
    logic          empty_r;
    logic          do_push_s;
    logic          do_pop_s;
    logic [CW-1:0] count_nxt_s;

    assign do_push_s = push & ~full_r;
    assign do_pop_s  = pop & ~empty_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_nxt_s = count_r + CW'(1'b1);
        end else if (do_pop_s && !do_push_s) begin
            count_nxt_s = count_r - CW'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage, pointers and flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == {CW{1'b0}});
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues buffered commands to the clock-gated ALU one at a time, holds operands for the
// mode-dependent number of cycles, then returns the captured result in command order.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int HOLD_BASE = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_opcode,
    input  logic [1:0]       power_mode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    output logic [1:0]       alu_power_mode,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic [2:0]       rsp_opcode,
    output logic             rsp_err,
    output logic             busy
);

    localparam int ENT_W = 2 * WIDTH + 3;
    localparam int CNT_W = $clog2(HOLD_BASE << 3) + 1;

    logic [ENT_W-1:0] head_s;
    logic [2:0]       head_op_s;
    logic [WIDTH-1:0] head_a_s;
    logic [WIDTH-1:0] head_b_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             pop_s;
    logic [CNT_W-1:0] hold_m1_s;

    state_t           state_r,      state_nxt_s;
    logic [CNT_W-1:0] cnt_r,        cnt_nxt_s;
    logic [WIDTH-1:0] alu_a_r,      alu_a_nxt_s;
    logic [WIDTH-1:0] alu_b_r,      alu_b_nxt_s;
    logic [2:0]       alu_op_r,     alu_op_nxt_s;
    logic [1:0]       alu_pm_r,     alu_pm_nxt_s;
    logic             alu_en_r,     alu_en_nxt_s;
    logic             rsp_valid_r,  rsp_valid_nxt_s;
    logic [WIDTH-1:0] rsp_result_r, rsp_result_nxt_s;
    logic             rsp_cout_r,   rsp_cout_nxt_s;
    logic [2:0]       rsp_op_r,     rsp_op_nxt_s;
    logic             rsp_err_r,    rsp_err_nxt_s;

    alu_cmd_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (cmd_valid),
        .wdata ({cmd_opcode, cmd_a, cmd_b}),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign head_op_s = head_s[ENT_W-1 -: 3];
    assign head_a_s  = head_s[2*WIDTH-1 -: WIDTH];
    assign head_b_s  = head_s[WIDTH-1:0];
    assign hold_m1_s = (CNT_W'(HOLD_BASE) << power_mode) - CNT_W'(1'b1);

    assign cmd_ready      = ~fifo_full_s;
    assign busy           = (state_r != ST_IDLE) | ~fifo_empty_s;
    assign alu_a          = alu_a_r;
    assign alu_b          = alu_b_r;
    assign alu_opcode     = alu_op_r;
    assign alu_power_mode = alu_pm_r;
    assign alu_enable     = alu_en_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_result     = rsp_result_r;
    assign rsp_cout       = rsp_cout_r;
    assign rsp_opcode     = rsp_op_r;
    assign rsp_err        = rsp_err_r;

    // Next-state and next-output logic; every register holds unless a branch updates it.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        alu_a_nxt_s      = alu_a_r;
        alu_b_nxt_s      = alu_b_r;
        alu_op_nxt_s     = alu_op_r;
        alu_pm_nxt_s     = alu_pm_r;
        alu_en_nxt_s     = alu_en_r;
        rsp_valid_nxt_s  = rsp_valid_r;
        rsp_result_nxt_s = rsp_result_r;
        rsp_cout_nxt_s   = rsp_cout_r;
        rsp_op_nxt_s     = rsp_op_r;
        rsp_err_nxt_s    = rsp_err_r;
        pop_s            = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (op_illegal(head_op_s)) begin
                        // Rejected without touching the ALU inputs.
                        rsp_result_nxt_s = {WIDTH{1'b0}};
                        rsp_cout_nxt_s   = 1'b0;
                        rsp_op_nxt_s     = head_op_s;
                        rsp_err_nxt_s    = 1'b1;
                        rsp_valid_nxt_s  = 1'b1;
                        state_nxt_s      = ST_RESP;
                    end else begin
                        alu_a_nxt_s  = head_a_s;
                        alu_b_nxt_s  = head_b_s;
                        alu_op_nxt_s = head_op_s;
                        alu_pm_nxt_s = power_mode;
                        alu_en_nxt_s = 1'b1;
                        cnt_nxt_s    = hold_m1_s;
                        state_nxt_s  = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_nxt_s = cnt_r - CNT_W'(1'b1);
                end else begin
                    rsp_result_nxt_s = alu_result;
                    rsp_cout_nxt_s   = alu_cout;
                    rsp_op_nxt_s     = alu_op_r;
                    rsp_err_nxt_s    = 1'b0;
                    rsp_valid_nxt_s  = 1'b1;
                    alu_en_nxt_s     = 1'b0;
                    state_nxt_s      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            alu_a_r      <= {WIDTH{1'b0}};
            alu_b_r      <= {WIDTH{1'b0}};
            alu_op_r     <= 3'b000;
            alu_pm_r     <= 2'b00;
            alu_en_r     <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= {WIDTH{1'b0}};
            rsp_cout_r   <= 1'b0;
            rsp_op_r     <= 3'b000;
            rsp_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            alu_a_r      <= alu_a_nxt_s;
            alu_b_r      <= alu_b_nxt_s;
            alu_op_r     <= alu_op_nxt_s;
            alu_pm_r     <= alu_pm_nxt_s;
            alu_en_r     <= alu_en_nxt_s;
            rsp_valid_r  <= rsp_valid_nxt_s;
            rsp_result_r <= rsp_result_nxt_s;
            rsp_cout_r   <= rsp_cout_nxt_s;
            rsp_op_r     <= rsp_op_nxt_s;
            rsp_err_r    <= rsp_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model on the alu_* port.
module tb_alu_op_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_opcode;
    logic [1:0]  power_mode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [1:0]  alu_power_mode;
    logic        alu_enable;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout;
    logic [2:0]  rsp_opcode;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_op_sequencer #(.WIDTH(32), .DEPTH(4), .HOLD_BASE(2)) dut (
        .Clk(Clk), .Rst(Rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .power_mode(power_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_power_mode(alu_power_mode), .alu_enable(alu_enable),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Behavioural ALU: SUB carry-out is the borrow.
    logic [32:0] alu_tmp;
    always_comb begin
        alu_tmp = 33'd0;
        case (alu_opcode)
            3'b000:  alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  alu_tmp = {1'b0, alu_a & alu_b};
            3'b011:  alu_tmp = {1'b0, alu_a | alu_b};
            3'b100:  alu_tmp = {1'b0, alu_a ^ alu_b};
            3'b101:  alu_tmp = {1'b0, ~alu_a};
            default: alu_tmp = 33'd0;
        endcase
    end
    assign alu_result = alu_tmp[31:0];
    assign alu_cout   = alu_tmp[32];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // Presents one command for a single cycle; returns on the negedge after the push edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        cmd_a      = a;
        cmd_b      = b;
        cmd_opcode = op;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_issue(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(alu_enable || rsp_valid) && lat < 40);
    endtask

    // Called on the first negedge after issue; counts cycles until rsp_valid and enable-high cycles.
    task automatic wait_rsp(output int hold, output int en_cnt);
        hold   = 0;
        en_cnt = alu_enable ? 1 : 0;
        while (!rsp_valid && hold < 40) begin
            tick();
            hold++;
            if (alu_enable) en_cnt++;
        end
    endtask

    task automatic accept(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq(tag, {63'd0, rsp_valid}, 64'd0);
    endtask

    logic [2:0]  exp_op  [5];
    logic [32:0] exp_res [5];
    logic [31:0] in_a    [5];
    logic [31:0] in_b    [5];
    logic [2:0]  got_op  [5];
    logic [32:0] got_res [5];

    initial begin
        int lat;
        int hold;
        int en_cnt;
        int n;
        int stray;

        Rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; power_mode = 2'b00;
        cmd_a = 32'd0; cmd_b = 32'd0; cmd_opcode = 3'b000;
        tick(); tick(); tick();
        check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check_eq("rst_alu_enable", {63'd0, alu_enable}, 64'd0);
        check_eq("rst_alu_a", {32'd0, alu_a}, 64'd0);
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        Rst = 1'b0;
        tick();

        // ADD 5+3 at mode 00
        send(32'h0000_0005, 32'h0000_0003, 3'b000);
        check_eq("add_busy", {63'd0, busy}, 64'd1);
        wait_issue(lat);
        check_eq("add_issue_lat", 64'(lat), 64'd1);
        check_eq("add_alu_a", {32'd0, alu_a}, 64'h5);
        wait_rsp(hold, en_cnt);
        check_eq("add_hold", 64'(hold), 64'd2);
        check_eq("add_en_cycles", 64'(en_cnt), 64'd2);
        check_eq("add_result", {31'd0, rsp_cout, rsp_result}, 64'h8);
        check_eq("add_err", {63'd0, rsp_err}, 64'd0);
        accept("add_accept");

        // SUB 3-5 at mode 11
        power_mode = 2'b11;
        send(32'h0000_0003, 32'h0000_0005, 3'b001);
        wait_issue(lat);
        check_eq("sub_pm", {62'd0, alu_power_mode}, 64'd3);
        wait_rsp(hold, en_cnt);
        check_eq("sub_hold", 64'(hold), 64'd16);
        check_eq("sub_en_cycles", 64'(en_cnt), 64'd16);
        check_eq("sub_result", {31'd0, rsp_cout, rsp_result}, 64'h1_FFFF_FFFE);
        check_eq("sub_opcode", {61'd0, rsp_opcode}, 64'd1);
        accept("sub_accept");
        power_mode = 2'b00;

        // Five back-to-back commands under response back-pressure
        in_a[0] = 32'h0000_00FF; in_b[0] = 32'h0000_0F0F; exp_op[0] = 3'b010; exp_res[0] = 33'h0_0000_000F;
        in_a[1] = 32'h0000_00F0; in_b[1] = 32'h0000_000F; exp_op[1] = 3'b011; exp_res[1] = 33'h0_0000_00FF;
        in_a[2] = 32'h0000_FFFF; in_b[2] = 32'h0000_00FF; exp_op[2] = 3'b100; exp_res[2] = 33'h0_0000_FF00;
        in_a[3] = 32'h0000_0000; in_b[3] = 32'h1234_5678; exp_op[3] = 3'b101; exp_res[3] = 33'h0_FFFF_FFFF;
        in_a[4] = 32'hFFFF_FFFF; in_b[4] = 32'h0000_0001; exp_op[4] = 3'b000; exp_res[4] = 33'h1_0000_0000;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("burst_ready_%0d", i), {63'd0, cmd_ready}, 64'd1);
            cmd_a = in_a[i]; cmd_b = in_b[i]; cmd_opcode = exp_op[i]; cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("burst_full", {63'd0, cmd_ready}, 64'd0);
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 5; c++) begin
            if (rsp_valid) begin
                got_op[n]  = rsp_opcode;
                got_res[n] = {rsp_cout, rsp_result};
                n++;
            end
            tick();
        end
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) stray++;
            tick();
        end
        rsp_ready = 1'b0;
        check_eq("burst_count", 64'(n), 64'd5);
        check_eq("burst_extra", 64'(stray), 64'd0);
        for (int i = 0; i < 5 && i < n; i++) begin
            check_eq($sformatf("burst_op_%0d", i), {61'd0, got_op[i]}, {61'd0, exp_op[i]});
            check_eq($sformatf("burst_res_%0d", i), {31'd0, got_res[i]}, {31'd0, exp_res[i]});
        end
        check_eq("burst_idle", {63'd0, busy}, 64'd0);

        // Illegal opcode 111
        send(32'hDEAD_BEEF, 32'h0000_0001, 3'b111);
        check_eq("ill_pre_valid", {63'd0, rsp_valid}, 64'd0);
        tick();
        check_eq("ill_valid", {63'd0, rsp_valid}, 64'd1);
        check_eq("ill_err", {63'd0, rsp_err}, 64'd1);
        check_eq("ill_result", {31'd0, rsp_cout, rsp_result}, 64'd0);
        check_eq("ill_enable", {63'd0, alu_enable}, 64'd0);
        check_eq("ill_alu_a_held", {32'd0, alu_a}, 64'hFFFF_FFFF);
        accept("ill_accept");

        // power_mode changes during WAIT only affect the next issue
        send(32'h0000_0001, 32'h0000_0002, 3'b000);
        wait_issue(lat);
        power_mode = 2'b10;
        wait_rsp(hold, en_cnt);
        check_eq("pm_first_hold", 64'(hold), 64'd2);
        check_eq("pm_first_result", {31'd0, rsp_cout, rsp_result}, 64'h3);
        accept("pm_first_accept");
        send(32'h0000_0010, 32'h0000_0001, 3'b001);
        wait_issue(lat);
        check_eq("pm_second_mode", {62'd0, alu_power_mode}, 64'd2);
        wait_rsp(hold, en_cnt);
        check_eq("pm_second_hold", 64'(hold), 64'd8);
        check_eq("pm_second_result", {31'd0, rsp_cout, rsp_result}, 64'hF);
        accept("pm_second_accept");

        // Reset in the middle of WAIT with two commands queued
        power_mode = 2'b11;
        send(32'h0000_0007, 32'h0000_0001, 3'b000);
        wait_issue(lat);
        send(32'h0000_0001, 32'h0000_0001, 3'b000);
        send(32'h0000_0002, 32'h0000_0002, 3'b010);
        check_eq("mid_enable", {63'd0, alu_enable}, 64'd1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_eq("rst2_enable", {63'd0, alu_enable}, 64'd0);
        check_eq("rst2_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst2_busy", {63'd0, busy}, 64'd0);
        check_eq("rst2_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        rsp_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (rsp_valid || alu_enable) stray++;
        end
        rsp_ready = 1'b0;
        check_eq("rst2_no_activity", 64'(stray), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
